// File: rtl/ram_arbiter.sv
// Arbitrates a single-port data RAM between the CPU MEM stage and a host port.
// The CPU owns the RAM by default; the host wins when the CPU is idle or has starved it long enough.
module ram_arbiter #(
    parameter int ADDR_BITS    = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_rw,
    input  logic [ADDR_BITS-3:0] cpu_addr,
    input  logic [31:0]          cpu_data_in,
    input  logic [3:0]           cpu_sel,
    output logic [31:0]          cpu_data_out,
    output logic                 cpu_stall,
    input  logic                 host_req,
    input  logic                 host_rw,
    input  logic [ADDR_BITS-3:0] host_addr,
    input  logic [31:0]          host_data_in,
    input  logic [3:0]           host_sel,
    output logic                 host_ack,
    output logic [31:0]          host_data_out,
    output logic [ADDR_BITS-3:0] ram_addr,
    output logic [31:0]          ram_data_in,
    output logic [3:0]           ram_sel,
    output logic                 ram_rw,
    input  logic [31:0]          ram_data_out,
    output logic [31:0]          host_access_num,
    output logic [31:0]          stall_cycles
);

    // +2 keeps the counter at least one bit wide even for a zero limit
    localparam int CNT_W = $clog2(STARVE_LIMIT + 2);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        CPU_OWN,
        HOST_ACC,
        HOST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_starve_cnt;
    logic [CNT_W-1:0] w_starve_next;
    logic [31:0]      r_host_data_out;
    logic [31:0]      r_host_access_num;
    logic [31:0]      r_stall_cycles;

    always_comb begin
        w_state_next  = r_state;
        w_starve_next = r_starve_cnt;
        ram_addr      = cpu_addr;
        ram_data_in   = cpu_data_in;
        ram_sel       = cpu_sel;
        ram_rw        = cpu_rw & cpu_req;
        cpu_stall     = 1'b0;
        host_ack      = 1'b0;
        case (r_state)
            CPU_OWN: begin
                if (host_req && (!cpu_req || r_starve_cnt == LIMIT)) begin
                    w_state_next  = HOST_ACC;
                    w_starve_next = '0;
                end else if (host_req && cpu_req) begin
                    // no transition here implies the count is still below the limit
                    w_starve_next = r_starve_cnt + CNT_W'(1);
                end
            end
            HOST_ACC: begin
                w_state_next = HOST_DONE;
                ram_addr     = host_addr;
                ram_data_in  = host_data_in;
                ram_sel      = host_sel;
                ram_rw       = host_rw;
                cpu_stall    = cpu_req;
            end
            HOST_DONE: begin
                // RAM already back with the CPU so it gets an unstalled cycle
                w_state_next = CPU_OWN;
                host_ack     = 1'b1;
            end
            default: w_state_next = CPU_OWN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= CPU_OWN;
            r_starve_cnt      <= '0;
            r_host_data_out   <= '0;
            r_host_access_num <= '0;
            r_stall_cycles    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= w_starve_next;
            if (r_state == HOST_ACC && !host_rw) begin
                r_host_data_out <= ram_data_out;
            end
            if (r_state == HOST_DONE) begin
                r_host_access_num <= r_host_access_num + 32'd1;
            end
            if (cpu_stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign cpu_data_out    = ram_data_out;
    assign host_data_out   = r_host_data_out;
    assign host_access_num = r_host_access_num;
    assign stall_cycles    = r_stall_cycles;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized CPU/host traffic
// compared against a cycle-level ownership model and a shadow copy of the RAM.
module tb_ram_arbiter;

    localparam int AB    = 12;
    localparam int AW    = AB - 2;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req, cpu_rw;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_data_in;
    logic [3:0]    cpu_sel;
    logic [31:0]   cpu_data_out;
    logic          cpu_stall;
    logic          host_req, host_rw;
    logic [AW-1:0] host_addr;
    logic [31:0]   host_data_in;
    logic [3:0]    host_sel;
    logic          host_ack;
    logic [31:0]   host_data_out;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_data_in;
    logic [3:0]    ram_sel;
    logic          ram_rw;
    logic [31:0]   ram_data_out;
    logic [31:0]   host_access_num, stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    ram_arbiter #(.ADDR_BITS(AB), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
        .cpu_data_in(cpu_data_in), .cpu_sel(cpu_sel),
        .cpu_data_out(cpu_data_out), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_rw(host_rw), .host_addr(host_addr),
        .host_data_in(host_data_in), .host_sel(host_sel),
        .host_ack(host_ack), .host_data_out(host_data_out),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_sel(ram_sel),
        .ram_rw(ram_rw), .ram_data_out(ram_data_out),
        .host_access_num(host_access_num), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Environment RAM: combinational read, byte-lane write on the rising edge
    logic [31:0] ram_mem [0:(1<<AW)-1];
    logic        mem_clear = 1'b1;
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < (1 << AW); i++) ram_mem[i] <= '0;
        end else if (ram_rw) begin
            for (int b = 0; b < 4; b++)
                if (ram_sel[b]) ram_mem[ram_addr][8*b +: 8] <= ram_data_in[8*b +: 8];
        end
    end
    assign ram_data_out = ram_mem[ram_addr];

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_rw = 0; cpu_addr = '0; cpu_data_in = '0; cpu_sel = '0;
        host_req = 0; host_rw = 0; host_addr = '0; host_data_in = '0; host_sel = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    // Returns the number of cycles until host_ack is seen, or -1 on expiry
    task automatic wait_ack(input int max_cyc, output int n);
        n = -1;
        for (int i = 0; i <= max_cyc; i++) begin
            if (host_ack) begin
                n = i;
                return;
            end
            step();
        end
    endtask

    task automatic host_op(input logic rw, input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int n, output logic [31:0] rd);
        host_req = 1; host_rw = rw; host_addr = a; host_data_in = d; host_sel = s;
        wait_ack(12, n);
        rd = host_data_out;
        step();
        host_req = 0;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        cpu_req = 1;
        rst = 1;
        mem_clear = 1;
        step();
        step();
        mem_clear = 0;
        n_cmp++; if (host_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b expected 0", host_ack); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", cpu_stall); end
        n_cmp++; if (host_data_out !== 32'h0) begin n_bad++; $display("FAIL reset_hdo: got %h expected 0", host_data_out); end
        n_cmp++; if (host_access_num !== 32'h0) begin n_bad++; $display("FAIL reset_num: got %0d expected 0", host_access_num); end
        n_cmp++; if (stall_cycles !== 32'h0) begin n_bad++; $display("FAIL reset_stalls: got %0d expected 0", stall_cycles); end
        rst = 0;
        cpu_req = 0;
        step();
    endtask

    task automatic test_idle_host();
        int n;
        logic [31:0] rd;
        do_reset();
        host_op(1'b1, 10'h010, 32'hDEADBEEF, 4'hF, n, rd);
        n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL idle_write_latency: got %0d expected 2", n); end
        host_op(1'b0, 10'h010, 32'h0, 4'hF, n, rd);
        n_cmp++; if (n !== 2) begin n_bad++; $display("FAIL idle_read_latency: got %0d expected 2", n); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL idle_readback: got %h expected deadbeef", rd); end
        n_cmp++; if (host_access_num !== 32'd2) begin n_bad++; $display("FAIL idle_access_num: got %0d expected 2", host_access_num); end
        n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL idle_stalls: got %0d expected 0", stall_cycles); end
    endtask

    task automatic test_starve();
        int first_stall = -1, nstall = 0, first_ack = -1;
        do_reset();
        cpu_req = 1; cpu_rw = 0; cpu_addr = 10'h010;
        host_req = 1; host_rw = 0; host_addr = 10'h010;
        for (int i = 0; i < 14; i++) begin
            if (cpu_stall) begin
                nstall++;
                if (first_stall < 0) first_stall = i;
            end
            if (host_ack && first_ack < 0) begin
                first_ack = i;
                host_req = 0;
            end
            step();
        end
        cpu_req = 0;
        n_cmp++; if (first_stall !== LIMIT + 1) begin n_bad++; $display("FAIL starve_grant_cycle: got %0d expected %0d", first_stall, LIMIT + 1); end
        n_cmp++; if (nstall !== 1) begin n_bad++; $display("FAIL starve_stall_len: got %0d expected 1", nstall); end
        n_cmp++; if (first_ack !== LIMIT + 2) begin n_bad++; $display("FAIL starve_ack_cycle: got %0d expected %0d", first_ack, LIMIT + 2); end
        n_cmp++; if (stall_cycles !== 32'd1) begin n_bad++; $display("FAIL starve_stall_count: got %0d expected 1", stall_cycles); end
    endtask

    // Two conflict cycles, a pause with host_req low, then the count resumes where it stopped
    task automatic test_starve_hold();
        int first_stall = -1, hold_stall = 0, n;
        do_reset();
        cpu_req = 1; cpu_rw = 0; cpu_addr = 10'h010;
        host_req = 1; host_rw = 0; host_addr = 10'h010;
        step();
        step();
        host_req = 0;
        for (int i = 0; i < 3; i++) begin
            if (cpu_stall) hold_stall++;
            step();
        end
        host_req = 1;
        for (int i = 0; i < 8 && first_stall < 0; i++) begin
            if (cpu_stall) first_stall = i;
            else step();
        end
        wait_ack(4, n);
        step();
        host_req = 0; cpu_req = 0;
        n_cmp++; if (hold_stall !== 0) begin n_bad++; $display("FAIL hold_no_stall: got %0d expected 0", hold_stall); end
        n_cmp++; if (first_stall !== LIMIT - 1) begin n_bad++; $display("FAIL hold_resume_grant: got %0d expected %0d", first_stall, LIMIT - 1); end
    endtask

    task automatic test_back_to_back();
        int acks[$];
        do_reset();
        host_req = 1; host_rw = 0; host_addr = 10'h010;
        for (int i = 0; i < 12; i++) begin
            if (host_ack) acks.push_back(i);
            step();
        end
        host_req = 0;
        step();
        n_cmp++; if (acks.size() !== 4) begin n_bad++; $display("FAIL b2b_ack_count: got %0d expected 4", acks.size()); end
        for (int k = 0; k < acks.size(); k++) begin
            n_cmp++; if (acks[k] !== 2 + 3 * k) begin n_bad++; $display("FAIL b2b_ack_time[%0d]: got %0d expected %0d", k, acks[k], 2 + 3 * k); end
        end
        n_cmp++; if (host_access_num !== 32'd4) begin n_bad++; $display("FAIL b2b_access_num: got %0d expected 4", host_access_num); end
    endtask

    task automatic test_cpu_store_conflict();
        do_reset();
        host_req = 1; host_rw = 0; host_addr = 10'h030;
        step();
        cpu_req = 1; cpu_rw = 1; cpu_addr = 10'h020; cpu_data_in = 32'h12345678; cpu_sel = 4'hF;
        #1;
        n_cmp++; if (cpu_stall !== 1'b1) begin n_bad++; $display("FAIL store_stall: got %b expected 1", cpu_stall); end
        n_cmp++; if (ram_rw !== 1'b0) begin n_bad++; $display("FAIL store_ram_rw_acc: got %b expected 0", ram_rw); end
        step();
        n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL store_unstalled: got %b expected 0", cpu_stall); end
        n_cmp++; if (host_ack !== 1'b1) begin n_bad++; $display("FAIL store_ack: got %b expected 1", host_ack); end
        n_cmp++; if (ram_rw !== 1'b1) begin n_bad++; $display("FAIL store_ram_rw_done: got %b expected 1", ram_rw); end
        host_req = 0;
        step();
        cpu_req = 0; cpu_rw = 0;
        #1;
        n_cmp++; if (ram_mem[10'h020] !== 32'h12345678) begin n_bad++; $display("FAIL store_committed: got %h expected 12345678", ram_mem[10'h020]); end
    endtask

    task automatic test_byte_write();
        int n;
        logic [31:0] rd;
        do_reset();
        host_op(1'b1, 10'h050, 32'h11223344, 4'hF, n, rd);
        host_op(1'b1, 10'h050, 32'h000000AA, 4'b0001, n, rd);
        host_op(1'b0, 10'h050, 32'h0, 4'hF, n, rd);
        n_cmp++; if (rd !== 32'h112233AA) begin n_bad++; $display("FAIL byte_word: got %h expected 112233aa", rd); end
        n_cmp++; if (rd[7:0] !== 8'hAA) begin n_bad++; $display("FAIL byte_lane0: got %h expected aa", rd[7:0]); end
    endtask

    task automatic test_reset_in_acc();
        int n, late_acks = 0;
        logic [31:0] rd;
        do_reset();
        host_op(1'b0, 10'h010, 32'h0, 4'hF, n, rd);
        n_cmp++; if (host_access_num !== 32'd1) begin n_bad++; $display("FAIL rstacc_pre_num: got %0d expected 1", host_access_num); end
        n_cmp++; if (host_data_out !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rstacc_pre_hdo: got %h expected deadbeef", host_data_out); end
        host_req = 1; host_rw = 1; host_addr = 10'h040; host_data_in = 32'h55; host_sel = 4'hF;
        step();
        cpu_req = 1;
        #1;
        n_cmp++; if (cpu_stall !== 1'b1) begin n_bad++; $display("FAIL rstacc_in_acc: got %b expected 1", cpu_stall); end
        rst = 1;
        step();
        n_cmp++; if (host_ack !== 1'b0) begin n_bad++; $display("FAIL rstacc_ack: got %b expected 0", host_ack); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL rstacc_stall: got %b expected 0", cpu_stall); end
        n_cmp++; if (host_access_num !== 32'd0) begin n_bad++; $display("FAIL rstacc_num: got %0d expected 0", host_access_num); end
        n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL rstacc_stalls: got %0d expected 0", stall_cycles); end
        n_cmp++; if (host_data_out !== 32'd0) begin n_bad++; $display("FAIL rstacc_hdo: got %h expected 0", host_data_out); end
        rst = 0; host_req = 0; cpu_req = 0;
        for (int i = 0; i < 4; i++) begin
            if (host_ack) late_acks++;
            step();
        end
        n_cmp++; if (late_acks !== 0) begin n_bad++; $display("FAIL rstacc_late_ack: got %0d expected 0", late_acks); end
    endtask

    // Random traffic on words 0x100..0x10F; the model tracks who owns the RAM each cycle
    task automatic test_random();
        logic [31:0] shadow [16];
        int          m_phase = 0;      // 0 CPU owns, 1 host accessing, 2 host done
        int          m_starve = 0;
        int          m_acks = 0, m_stalls = 0, idx;
        logic [31:0] m_hdo = '0;
        logic        h_active = 0, exp_stall, exp_ack;
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            if (!h_active && $urandom_range(0, 2) == 0) begin
                h_active     = 1;
                host_rw      = 1'($urandom_range(0, 1));
                host_addr    = 10'h100 + 10'($urandom_range(0, 15));
                host_data_in = $urandom;
                host_sel     = 4'($urandom_range(0, 15));
            end
            host_req    = h_active;
            cpu_req     = 1'($urandom_range(0, 1));
            cpu_rw      = 1'($urandom_range(0, 1));
            cpu_addr    = 10'h100 + 10'($urandom_range(0, 15));
            cpu_data_in = $urandom;
            cpu_sel     = 4'($urandom_range(0, 15));
            #1;
            exp_stall = (m_phase == 1) && cpu_req;
            exp_ack   = (m_phase == 2);
            n_cmp++; if (cpu_stall !== exp_stall) begin n_bad++; $display("FAIL rnd_stall@%0d: got %b expected %b", c, cpu_stall, exp_stall); end
            n_cmp++; if (host_ack !== exp_ack) begin n_bad++; $display("FAIL rnd_ack@%0d: got %b expected %b", c, host_ack, exp_ack); end
            n_cmp++; if (host_data_out !== m_hdo) begin n_bad++; $display("FAIL rnd_hdo@%0d: got %h expected %h", c, host_data_out, m_hdo); end
            if (m_phase != 1 && cpu_req && !cpu_rw) begin
                idx = int'(cpu_addr) - 256;
                n_cmp++; if (cpu_data_out !== shadow[idx]) begin n_bad++; $display("FAIL rnd_cpu_rd@%0d: got %h expected %h", c, cpu_data_out, shadow[idx]); end
            end
            if (m_phase == 1) begin
                idx = int'(host_addr) - 256;
                if (host_rw) shadow[idx] = merge(shadow[idx], host_data_in, host_sel);
                else m_hdo = shadow[idx];
            end else if (cpu_req && cpu_rw) begin
                idx = int'(cpu_addr) - 256;
                shadow[idx] = merge(shadow[idx], cpu_data_in, cpu_sel);
            end
            if (exp_stall) m_stalls++;
            if (exp_ack) begin
                m_acks++;
                h_active = 0;
            end
            if (m_phase == 0) begin
                if (host_req && (!cpu_req || m_starve >= LIMIT)) begin
                    m_phase  = 1;
                    m_starve = 0;
                end else if (host_req && cpu_req) begin
                    m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
                end
            end else begin
                m_phase = (m_phase == 1) ? 2 : 0;
            end
            step();
        end
        n_cmp++; if (host_access_num !== 32'(m_acks)) begin n_bad++; $display("FAIL rnd_access_num: got %0d expected %0d", host_access_num, m_acks); end
        n_cmp++; if (stall_cycles !== 32'(m_stalls)) begin n_bad++; $display("FAIL rnd_stall_cycles: got %0d expected %0d", stall_cycles, m_stalls); end
        idle_inputs();
        step();
        step();
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (ram_mem[256 + i] !== shadow[i]) begin n_bad++; $display("FAIL rnd_mem[%0d]: got %h expected %h", 256 + i, ram_mem[256 + i], shadow[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_idle_host();
        test_starve();
        test_starve_hold();
        test_back_to_back();
        test_cpu_store_conflict();
        test_byte_write();
        test_reset_in_acc();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 12, RAM byte-address width; the word address is ADDR_BITS-2 bits.
REQ-002 Parameter STARVE_LIMIT, default 4, number of consecutive CPU-won conflict cycles before the host is forced a grant.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cpu_req  in  1  CPU MEM-stage access this cycle (load or store).
REQ-006 cpu_rw, cpu_addr[ADDR_BITS-3:0], cpu_data_in[31:0], cpu_sel[3:0]  in  CPU write enable, word address, write data, byte lanes.
REQ-007 cpu_data_out  out  32  RAM read data routed to the CPU.
REQ-008 cpu_stall  out  1  CPU pipeline must freeze this cycle.
REQ-009 host_req  in  1  host (debug/loader) access request; held high with stable operands until host_ack.
REQ-010 host_rw, host_addr[ADDR_BITS-3:0], host_data_in[31:0], host_sel[3:0]  in  host operands.
REQ-011 host_ack  out  1  one-cycle completion pulse.
REQ-012 host_data_out  out  32  registered host read data, valid while host_ack=1 and held until the next host read.
REQ-013 ram_addr[ADDR_BITS-3:0], ram_data_in[31:0], ram_sel[3:0], ram_rw  out  to the single-port data RAM.
REQ-014 ram_data_out  in  32  combinational RAM read data.
REQ-015 host_access_num, stall_cycles  out  32 each  statistics counters.

Function
REQ-016 FSM states: CPU_OWN, HOST_ACC, HOST_DONE.
REQ-017 CPU_OWN -> HOST_ACC when host_req && (!cpu_req || starve_cnt == STARVE_LIMIT); otherwise remain in CPU_OWN.
REQ-018 HOST_ACC -> HOST_DONE unconditionally; HOST_DONE -> CPU_OWN unconditionally, regardless of host_req.
REQ-019 In CPU_OWN and HOST_DONE: RAM ports = CPU operands; ram_rw = cpu_rw & cpu_req; cpu_stall = 0.
REQ-020 In HOST_ACC: RAM ports = host operands; ram_rw = host_rw; cpu_stall = cpu_req; host write commits at the closing edge.
REQ-021 In HOST_ACC, if host_rw = 0: host_data_out <= ram_data_out at the closing edge.
REQ-022 host_ack = 1 only in HOST_DONE; minimum latency is 2 cycles from the first sampled host_req edge to host_ack.
REQ-023 cpu_data_out = ram_data_out in all states.
REQ-024 starve_cnt: increments, saturating at STARVE_LIMIT, in CPU_OWN when host_req && cpu_req and no transition occurs; cleared on entry to HOST_ACC.
REQ-025 starve_cnt holds its value in CPU_OWN when host_req = 0.
REQ-026 At most one host access per three cycles; HOST_DONE guarantees the CPU at least one unstalled cycle between host accesses.
REQ-027 host_access_num increments by 1 in each HOST_DONE cycle; wraps modulo 2^32.
REQ-028 stall_cycles increments by 1 in each cycle with cpu_stall = 1; wraps modulo 2^32.
REQ-029 A host_req drop before host_ack is a protocol violation; the access still completes and host_ack still pulses.

Reset
REQ-030 rst = 1 at a rising edge: state -> CPU_OWN; starve_cnt, host_data_out, host_access_num, stall_cycles -> 0; host_ack = 0 and cpu_stall = 0 from the next cycle.
REQ-031 Reset in HOST_ACC aborts the access: no host_ack is issued, and a host write on that edge is not guaranteed committed.
REQ-032 Reset overrides every simultaneous event.

Verification
REQ-033 Idle CPU: host write addr 0x010, data 0xDEADBEEF, sel 4'b1111 -> host_ack at cycle 2; a subsequent host read of 0x010 returns 0xDEADBEEF; host_access_num = 2.
REQ-034 Continuous cpu_req = 1 with host_req raised (STARVE_LIMIT = 4) -> 4 CPU_OWN conflict cycles, then HOST_ACC with cpu_stall = 1 for exactly 1 cycle, host_ack on the next cycle; stall_cycles = 1.
REQ-035 host_req held high through a completed ack and cpu_req = 0 -> next access enters HOST_ACC no earlier than 1 cycle after HOST_DONE; host_ack period >= 3 cycles.
REQ-036 CPU store to 0x020 (0x12345678) in the same cycle the host is granted -> cpu_stall = 1, CPU store commits in the HOST_DONE cycle, and RAM holds 0x12345678.
REQ-037 rst asserted during HOST_ACC -> no host_ack, state CPU_OWN, all counters 0 in the next cycle.
REQ-038 Host byte write sel 4'b0001, data 0x000000AA -> only byte lane 0 changes; the read-back host_data_out low byte = 0xAA.
